// File: rtl/mul_unit.sv
// Iterative N-bit unsigned shift-add multiplier (MUL low half / UMULH high half) with regfile write-back.
// Latency N cycles from accept to the one-cycle done pulse; start is ignored while busy, except in DONE where it chains a new op.
module mul_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_start,
    input  logic         i_op,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [4:0]   i_rd,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] o_result,
    output logic [4:0]   o_wa_out,
    output logic         o_we_out
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [2*N-1:0] r_p;
    logic [N-1:0]   r_mcand;
    logic           r_op;
    logic [4:0]     r_rd;
    logic [CW-1:0]  r_cnt;
    logic           r_busy;
    logic           r_done;
    logic           r_we;
    logic [N-1:0]   r_result;
    logic [4:0]     r_wa;

    logic [N:0]     w_sum;
    logic [2*N-1:0] w_p_next;
    logic           w_last;
    logic           w_accept;

    // Carry out of the add lands in the top product bit after the shift.
    assign w_sum    = {1'b0, r_p[2*N-1:N]} + {1'b0, (r_p[0] ? r_mcand : {N{1'b0}})};
    assign w_p_next = {w_sum, r_p[N-1:1]};
    assign w_last   = (r_cnt == CW'(N-1));
    // Accepting in DONE keeps the initiation interval at N+1 for back-to-back issue.
    assign w_accept = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_mcand  <= '0;
            r_op     <= 1'b0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_result <= '0;
            r_wa     <= '0;
        end else begin
            r_done <= 1'b0;
            r_we   <= 1'b0;
            if (w_accept) begin
                r_mcand <= i_a;
                r_op    <= i_op;
                r_rd    <= i_rd;
                r_p     <= {{N{1'b0}}, i_b};
                r_cnt   <= '0;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
            end else begin
                case (r_state)
                    S_RUN: begin
                        r_p   <= w_p_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_we     <= (r_rd != 5'd31);
                            r_wa     <= r_rd;
                            r_result <= r_op ? w_p_next[2*N-1:N] : w_p_next[N-1:0];
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;
    assign o_wa_out = r_wa;
    assign o_we_out = r_we;
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: vector table, randomized ops against a product model, and timing corner sequences.
module tb_mul_unit;
    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         i_start;
    logic         i_op;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic [4:0]   i_rd;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_result;
    logic [4:0]   o_wa_out;
    logic         o_we_out;

    int errors = 0;
    int checks = 0;

    mul_unit #(.N(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_start  (i_start),
        .i_op     (i_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_rd     (i_rd),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result),
        .o_wa_out (o_wa_out),
        .o_we_out (o_we_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        op;
        logic [4:0]  rd;
        logic [63:0] exp_res;
        logic        exp_we;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b, input logic op);
        logic [127:0] p;
        p = {64'd0, a} * {64'd0, b};
        return op ? p[127:64] : p[63:0];
    endfunction

    // One complete operation: latency, busy span, single done/we pulse, results held afterwards.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic op,
                          input logic [4:0] rd, input logic [63:0] exp_res, input logic exp_we,
                          input string name);
        int done_idx;
        int busy_n;
        int done_n;
        int we_n;
        done_idx = -1; busy_n = 0; done_n = 0; we_n = 0;
        @(negedge clk);
        i_a = a; i_b = b; i_op = op; i_rd = rd; i_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (k == 0) i_start = 1'b0;
            if (o_busy) busy_n++;
            if (o_we_out) we_n++;
            if (o_done) begin
                done_n++;
                done_idx = k;
                chk({name, " result"}, o_result, exp_res);
                chk({name, " wa"}, 64'(o_wa_out), 64'(rd));
                chk({name, " we"}, 64'(o_we_out), 64'(exp_we));
            end
            if (!o_busy && !o_done) break;
        end
        chk({name, " latency"}, 64'(done_idx), 64'(N));
        chk({name, " busy cycles"}, 64'(busy_n), 64'(N + 1));
        chk({name, " done count"}, 64'(done_n), 64'd1);
        chk({name, " we count"}, 64'(we_n), 64'(exp_we));
        chk({name, " result held"}, o_result, exp_res);
    endtask

    initial begin
        vec_t vecs[5];
        logic [63:0] ra;
        logic [63:0] rb;
        logic        rop;
        logic [4:0]  rrd;
        int          ndone;
        int          d1;
        int          d2;

        vecs[0] = '{64'd3, 64'd5, 1'b0, 5'd9, 64'd15, 1'b1, "mul_3x5"};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd3,
                    64'hFFFF_FFFF_FFFF_FFFE, 1'b1, "umulh_max"};
        vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd4,
                    64'h0000_0000_0000_0001, 1'b1, "mul_max"};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'd2, 1'b1, 5'd5, 64'd1, 1'b1, "umulh_2p63x2"};
        vecs[4] = '{64'd7, 64'd6, 1'b0, 5'd31, 64'd42, 1'b0, "xzr_7x6"};

        reset = 1'b1; i_start = 1'b0; i_op = 1'b0; i_a = '0; i_b = '0; i_rd = '0;
        #3;
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        chk("reset we", 64'(o_we_out), 64'd0);
        chk("reset result", o_result, 64'd0);
        chk("reset wa", 64'(o_wa_out), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].rd, vecs[i].exp_res, vecs[i].exp_we, vecs[i].name);

        for (int i = 0; i < 6; i++) begin
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rop = 1'($urandom_range(0, 1));
            rrd = 5'($urandom_range(0, 31));
            run_op(ra, rb, rop, rrd, ref_mul(ra, rb, rop), rrd != 5'd31, "random");
        end

        // Start and operand changes while running must not disturb the captured op.
        @(negedge clk);
        i_a = 64'd10; i_b = 64'd10; i_op = 1'b0; i_rd = 5'd7; i_start = 1'b1;
        @(posedge clk);
        ndone = 0;
        for (int k = 0; k < N + 80; k++) begin
            @(negedge clk);
            if (k == 0) i_start = 1'b0;
            if (k == 20) begin i_a = 64'd1; i_b = 64'd1; i_rd = 5'd12; i_start = 1'b1; end
            if (k == 21) i_start = 1'b0;
            if (o_done) begin
                ndone++;
                chk("immune result", o_result, 64'd100);
                chk("immune wa", 64'(o_wa_out), 64'd7);
            end
        end
        chk("immune done count", 64'(ndone), 64'd1);

        // Asynchronous reset between edges 10 and 11 of a running op.
        @(negedge clk);
        i_a = 64'd4; i_b = 64'd4; i_rd = 5'd3; i_start = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 0) i_start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("midrst busy", 64'(o_busy), 64'd0);
        chk("midrst done", 64'(o_done), 64'd0);
        chk("midrst we", 64'(o_we_out), 64'd0);
        chk("midrst result", o_result, 64'd0);
        chk("midrst wa", 64'(o_wa_out), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (o_done || o_busy) ndone++;
        end
        chk("midrst no activity", 64'(ndone), 64'd0);
        run_op(64'd2, 64'd3, 1'b0, 5'd3, 64'd6, 1'b1, "post_reset");

        // Start held high: second op must be accepted on the edge leaving DONE.
        @(negedge clk);
        i_a = 64'd2; i_b = 64'd9; i_op = 1'b0; i_rd = 5'd1; i_start = 1'b1;
        @(posedge clk);
        ndone = 0; d1 = -1; d2 = -1;
        for (int k = 0; k < 260; k++) begin
            @(negedge clk);
            if (k == 0) begin i_a = 64'd3; i_b = 64'd3; i_rd = 5'd2; end
            if (d1 >= 0 && k == d1 + 1) i_start = 1'b0;
            if (o_done) begin
                ndone++;
                if (ndone == 1) begin
                    d1 = k;
                    chk("b2b first result", o_result, 64'd18);
                    chk("b2b first wa", 64'(o_wa_out), 64'd1);
                end else if (ndone == 2) begin
                    d2 = k;
                    chk("b2b second result", o_result, 64'd9);
                    chk("b2b second wa", 64'(o_wa_out), 64'd2);
                end
            end
        end
        if (d1 < 0) i_start = 1'b0;
        chk("b2b first latency", 64'(d1), 64'(N));
        chk("b2b spacing", 64'(d2 - d1), 64'(N + 1));
        chk("b2b done count", 64'(ndone), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
